mem_port_arbiter: RTL and testbench

Shares the core's single external memory port between instruction fetch (F stage) and load/store (M stage) of the 5-stage pipeline. It grants one requester at a time, drives a valid/ready memory handshake, and returns read data to the winner with a one-cycle valid pulse. It raises `stall_f`/`stall_m` to the pipeline while a request waits or is in flight, and discards fetch results made stale by a PC redirect.

---
 rtl/arb_pkg.sv | 17 +
 rtl/arb_starve_ctr.sv | 30 +++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and default parameters for the memory port arbiter.
package arb_pkg;
  localparam int ARB_XLEN       = 32;
  localparam int ARB_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;
endpackage

// File: rtl/arb_starve_ctr.sv
// Counts data grants made while fetch waits; flags starvation at STARVE_MAX.
module arb_starve_ctr
  import arb_pkg::*;
#(
  parameter int STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic i_fetch_req,
  input  logic i_data_grant,
  input  logic i_fetch_grant,
  output logic o_starved
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] LP_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_fetch_grant) begin
      r_cnt <= '0;
    end else if (i_data_grant && i_fetch_req && (r_cnt != LP_MAX)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_starved = (r_cnt == LP_MAX);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store with a valid/ready handshake.
// Define ARB_FAIRNESS_EN to force a waiting fetch through after STARVE_MAX data grants.
//   state  | meaning
//   IDLE   | port free; grant data first, else fetch
//   BUSY_I | fetch transfer on the memory port
//   BUSY_D | data transfer on the memory port
//   RESP   | completion pulse to owner; no new grant this cycle
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int XLEN       = ARB_XLEN,
  parameter int STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  input  logic            i_flush,
  output logic [XLEN-1:0] i_rdata,
  output logic            i_valid,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [3:0]      d_wstrb,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_valid,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            stall_f,
  output logic            stall_m
);
  arb_state_t      r_state, w_state_nxt;
  arb_owner_t      r_owner;
  logic            r_drop;
  logic            w_grant_i, w_grant_d, w_busy, w_force;
  logic            r_mem_we;
  logic [XLEN-1:0] r_mem_addr, r_mem_wdata, r_i_rdata, r_d_rdata;
  logic [3:0]      r_mem_wstrb;

`ifdef ARB_FAIRNESS_EN
  logic w_starved;

  arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve_ctr (
    .clk          (clk),
    .reset        (reset),
    .i_fetch_req  (i_req),
    .i_data_grant (w_grant_d),
    .i_fetch_grant(w_grant_i),
    .o_starved    (w_starved)
  );

  assign w_force = w_starved & i_req & ~i_flush;
`else
  // Keeps STARVE_MAX referenced when the fairness counter is compiled out.
  logic [31:0] w_unused_starve_max;
  assign w_unused_starve_max = 32'(STARVE_MAX);
  assign w_force = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    w_busy      = 1'b0;
    i_valid     = 1'b0;
    d_valid     = 1'b0;
    case (r_state)
      IDLE: begin
        if (d_req && !w_force) begin
          w_grant_d   = 1'b1;
          w_state_nxt = BUSY_D;
        end else if (i_req && !i_flush) begin
          w_grant_i   = 1'b1;
          w_state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        w_busy = 1'b1;
        if (mem_ready) w_state_nxt = RESP;
      end
      RESP: begin
        w_state_nxt = IDLE;
        i_valid     = (r_owner == OWN_I) && !r_drop && !i_flush;
        d_valid     = (r_owner == OWN_D);
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner     <= OWN_I;
      r_drop      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      if (w_grant_d) begin
        r_owner     <= OWN_D;
        r_mem_we    <= d_we;
        r_mem_addr  <= d_addr;
        r_mem_wdata <= d_wdata;
        r_mem_wstrb <= d_wstrb;
      end else if (w_grant_i) begin
        r_owner     <= OWN_I;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= i_addr;
        r_mem_wdata <= '0;
        r_mem_wstrb <= 4'b0000;
      end
      if (w_busy && mem_ready) begin
        if (r_state == BUSY_I) r_i_rdata <= mem_rdata;
        else                   r_d_rdata <= mem_rdata;
      end
      // A redirected fetch still finishes on the bus; only its pulse is dropped.
      if (w_state_nxt == IDLE)               r_drop <= 1'b0;
      else if (r_state == BUSY_I && i_flush) r_drop <= 1'b1;
    end
  end

  assign mem_req   = w_busy;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign stall_f   = i_req & ~i_valid;
  assign stall_m   = d_req & ~d_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level timing model.
module tb_mem_port_arbiter;
  localparam int XLEN       = 32;
  localparam int STARVE_MAX = 4;

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } iss_t;

  typedef struct {
    int          cyc;
    bit          is_d;
    logic [31:0] data;
    bit          chk_d;
  } val_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            i_req, i_flush, i_valid;
  logic [XLEN-1:0] i_addr, i_rdata;
  logic            d_req, d_we, d_valid;
  logic [XLEN-1:0] d_addr, d_wdata, d_rdata;
  logic [3:0]      d_wstrb;
  logic            mem_req, mem_we, mem_ready;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]      mem_wstrb;
  logic            stall_f, stall_m;

  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc = 0;
  int   mem_lat = 0;
  bit   mem_hold = 1'b0;
  int   wait_cnt = 0;
  bit   seen_iv = 1'b0;
  bit   seen_dv = 1'b0;
  iss_t obs_iss[$];
  val_t obs_val[$];

  mem_port_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5EED_C0DE;
  endfunction

  // Memory slave with programmable wait states, plus bus/handshake monitor.
  initial begin
    logic        hs, p_req, p_hs, p_we;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_wstrb;
    p_req = 1'b0; p_hs = 1'b0; p_we = 1'b0;
    p_addr = '0; p_wdata = '0; p_wstrb = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        mem_ready = !mem_hold && (wait_cnt >= mem_lat);
        wait_cnt  = mem_ready ? 0 : wait_cnt + 1;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        wait_cnt  = 0;
      end
      hs = mem_req & mem_ready;
      mem_rdata = hs ? mem_fn(mem_addr) : $urandom;
      chk_eq("stall_f", stall_f, i_req & ~i_valid);
      chk_eq("stall_m", stall_m, d_req & ~d_valid);
      if (mem_req && !p_req) obs_iss.push_back('{cyc, mem_we, mem_addr, mem_wdata, mem_wstrb});
      if (mem_req && p_req && !p_hs) begin
        chk_eq("hold_we", mem_we, p_we);
        chk_eq("hold_addr", mem_addr, p_addr);
        chk_eq("hold_wdata", mem_wdata, p_wdata);
        chk_eq("hold_wstrb", mem_wstrb, p_wstrb);
      end
      if (i_valid) begin
        obs_val.push_back('{cyc, 1'b0, i_rdata, 1'b1});
        seen_iv = 1'b1;
      end
      if (d_valid) begin
        obs_val.push_back('{cyc, 1'b1, d_rdata, 1'b1});
        seen_dv = 1'b1;
      end
      p_req = mem_req; p_hs = hs; p_we = mem_we;
      p_addr = mem_addr; p_wdata = mem_wdata; p_wstrb = mem_wstrb;
    end
  end

  task automatic do_reset();
    reset   = 1'b1;
    i_req   = 1'b0;
    d_req   = 1'b0;
    i_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One fetch and/or one data transaction raised together; expectations derived
  // from the port rules: issue 1 cycle after grant, valid 1 cycle after ready,
  // next grant 2 cycles after ready, data ahead of fetch.
  task automatic run_txn(input bit do_i, input bit do_d, input bit do_fl, input int lat,
                         input logic [31:0] ia0, input logic [31:0] ia1,
                         input logic [31:0] da, input logic [31:0] dw,
                         input logic [3:0] ds, input logic dwe);
    iss_t ei[$];
    val_t ev[$];
    int   t0, g, fc, budget, quiet;
    do_reset();
    mem_lat  = lat;
    mem_hold = 1'b0;
    @(posedge clk); #1;
    obs_iss.delete(); obs_val.delete();
    seen_iv = 1'b0; seen_dv = 1'b0;
    t0 = cyc;
    i_req = do_i; i_addr = ia0;
    d_req = do_d; d_we = dwe; d_addr = da; d_wdata = dw; d_wstrb = ds;
    g  = t0;
    fc = -1;
    if (do_d) begin
      ei.push_back('{g + 1, dwe, da, dw, ds});
      ev.push_back('{g + 2 + lat, 1'b1, mem_fn(da), !dwe});
      g = g + 3 + lat;
    end
    if (do_i) begin
      ei.push_back('{g + 1, 1'b0, ia0, 32'h0, 4'h0});
      if (do_fl) begin
        fc = g + 1 + $urandom_range(0, lat + 1);
        g  = g + 3 + lat;
        ei.push_back('{g + 1, 1'b0, ia1, 32'h0, 4'h0});
      end
      ev.push_back('{g + 2 + lat, 1'b0, mem_fn(do_fl ? ia1 : ia0), 1'b1});
    end
    budget = 0;
    quiet  = 0;
    while (quiet < 4 && budget < 80) begin
      @(posedge clk); #1;
      budget++;
      i_flush = (cyc == fc);
      if (cyc == fc) i_addr = ia1;
      if (seen_iv) begin i_req = 1'b0; seen_iv = 1'b0; end
      if (seen_dv) begin d_req = 1'b0; seen_dv = 1'b0; end
      quiet = (!i_req && !d_req) ? quiet + 1 : 0;
    end
    chk_eq("txn_timeout", budget < 80, 1'b1);
    chk_eq("n_issue", obs_iss.size(), ei.size());
    for (int k = 0; k < ei.size() && k < obs_iss.size(); k++) begin
      chk_eq("iss_cyc", obs_iss[k].cyc - t0, ei[k].cyc - t0);
      chk_eq("iss_we", obs_iss[k].we, ei[k].we);
      chk_eq("iss_addr", obs_iss[k].addr, ei[k].addr);
      chk_eq("iss_wstrb", obs_iss[k].wstrb, ei[k].wstrb);
      if (ei[k].wstrb != 4'h0) chk_eq("iss_wdata", obs_iss[k].wdata, ei[k].wdata);
    end
    chk_eq("n_valid", obs_val.size(), ev.size());
    for (int k = 0; k < ev.size() && k < obs_val.size(); k++) begin
      chk_eq("val_cyc", obs_val[k].cyc - t0, ev[k].cyc - t0);
      chk_eq("val_kind", obs_val[k].is_d, ev[k].is_d);
      if (ev[k].chk_d) chk_eq("val_data", obs_val[k].data, ev[k].data);
    end
  endtask

  task automatic run_fair();
    int budget;
    bit exp_f;
    do_reset();
    mem_lat  = $urandom_range(0, 2);
    mem_hold = 1'b0;
    @(posedge clk); #1;
    obs_iss.delete(); obs_val.delete();
    seen_iv = 1'b0; seen_dv = 1'b0;
    i_req = 1'b1; i_addr = $urandom & 32'hFFFF_FFFC;
    d_req = 1'b1; d_we = 1'b0; d_addr = $urandom & 32'hFFFF_FFFC;
    d_wdata = $urandom; d_wstrb = 4'hF;
    budget = 0;
    while (obs_iss.size() < 15 && budget < 300) begin
      @(posedge clk); #1;
      budget++;
      if (seen_iv) begin i_addr = $urandom & 32'hFFFF_FFFC; seen_iv = 1'b0; end
      if (seen_dv) begin d_addr = $urandom & 32'hFFFF_FFFC; seen_dv = 1'b0; end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    chk_eq("fair_timeout", budget < 300, 1'b1);
    for (int k = 0; k < obs_iss.size(); k++) begin
`ifdef ARB_FAIRNESS_EN
      exp_f = (k % (STARVE_MAX + 1)) == STARVE_MAX;
`else
      exp_f = 1'b0;
`endif
      chk_eq($sformatf("fair_kind%0d", k), obs_iss[k].wstrb == 4'h0, exp_f);
    end
  endtask

  task automatic run_rst();
    do_reset();
    mem_hold = 1'b1;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_wstrb = 4'hF; d_wdata = $urandom;
    repeat (3) @(posedge clk);
    #1 chk_eq("rst_pre_mem_req", mem_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk_eq("rst_mem_req", mem_req, 1'b0);
    chk_eq("rst_d_valid", d_valid, 1'b0);
    chk_eq("rst_mem_addr", mem_addr, 32'h0);
    chk_eq("rst_stall_m", stall_m, 1'b1);
    @(posedge clk); #1;
    d_req    = 1'b0;
    reset    = 1'b0;
    mem_hold = 1'b0;
    obs_val.delete();
    obs_iss.delete();
    repeat (10) @(posedge clk);
    #1;
    chk_eq("rst_no_valid", obs_val.size(), 0);
    chk_eq("rst_no_issue", obs_iss.size(), 0);
  endtask

  initial begin
    int sel;
    bit ri, rd;
    reset = 1'b1; i_req = 1'b1; i_addr = '0; i_flush = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_eq("rst_mem_req0", mem_req, 1'b0);
    chk_eq("rst_mem_we0", mem_we, 1'b0);
    chk_eq("rst_mem_addr0", mem_addr, 32'h0);
    chk_eq("rst_mem_wdata0", mem_wdata, 32'h0);
    chk_eq("rst_mem_wstrb0", mem_wstrb, 4'h0);
    chk_eq("rst_i_valid0", i_valid, 1'b0);
    chk_eq("rst_d_valid0", d_valid, 1'b0);
    chk_eq("rst_i_rdata0", i_rdata, 32'h0);
    chk_eq("rst_d_rdata0", d_rdata, 32'h0);
    chk_eq("rst_stall_f0", stall_f, 1'b1);
    chk_eq("rst_stall_m0", stall_m, 1'b1);

    run_txn(1'b1, 1'b0, 1'b0, 0, 32'h100, 32'h0, 32'h0, 32'h0, 4'hF, 1'b0);
    run_txn(1'b1, 1'b1, 1'b0, 0, 32'h300, 32'h0, 32'h2000, 32'hCAFE_F00D, 4'b0011, 1'b1);
    run_txn(1'b0, 1'b1, 1'b0, 5, 32'h0, 32'h0, 32'h1234, 32'h0, 4'hF, 1'b0);
    run_txn(1'b1, 1'b0, 1'b1, 2, 32'h400, 32'h800, 32'h0, 32'h0, 4'hF, 1'b0);
    run_txn(1'b1, 1'b1, 1'b1, 3, 32'h500, 32'h900, 32'h3000, 32'h0, 4'h1, 1'b0);
    for (int r = 0; r < 30; r++) begin
      sel = $urandom_range(0, 2);
      ri  = (sel != 1);
      rd  = (sel != 0);
      run_txn(ri, rd, ri && ($urandom_range(0, 2) == 0), $urandom_range(0, 5),
              $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
              $urandom & 32'hFFFF_FFFC, $urandom,
              4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
    end
    run_fair();
    run_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected end of run");
    $fatal(1, "watchdog expired");
  end
endmodule
